// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared register-address width and hazard FSM state encodings
package pipe_hazard_ctrl_pkg;
  localparam int ASIZE = 5;
  typedef enum logic {PHC_RUN = 1'b0, PHC_MEM_WAIT = 1'b1} phc_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// lu_detect: combinational load-use compare between the load in EXE and the ID operands
module lu_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memtoReg,
  input  logic [ASIZE-1:0] ex_waddr,
  output logic             lu
);
  assign lu = ex_memtoReg && ex_waddr != '0 && (ex_waddr == id_rs || (id_uses_rt && ex_waddr == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer with dmem wait timeout; PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memtoReg,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
`ifdef PIPE_PERF_CNT_EN
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`else
  output logic             mem_err
`endif
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  phc_state_t state, state_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic err, lu, timeout, stall;
  lu_detect u_lu (
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memtoReg(ex_memtoReg), .ex_waddr(ex_waddr), .lu(lu)
  );
  assign timeout = state == PHC_MEM_WAIT && !dmem_ready && cnt == TW'(MEM_TIMEOUT);
  assign stall = !rst && (state == PHC_RUN ? dmem_req && !dmem_ready : !dmem_ready && !timeout);
  // a timeout releases the pipe like a ready, but the lost access must not write back
  assign pc_en = !rst && !stall && (branch_taken || !lu);
  assign ifid_en = pc_en;
  assign exmem_en = !rst && !stall;
  assign ifid_flush = rst || (!stall && branch_taken);
  assign idex_flush = rst || (!stall && (branch_taken || lu));
  assign memwb_bubble = rst || stall || timeout;
  assign mem_err = err && !rst;
  always_comb begin
    state_nx = state == PHC_RUN ? (dmem_req && !dmem_ready ? PHC_MEM_WAIT : PHC_RUN)
                                : (dmem_ready || timeout ? PHC_RUN : PHC_MEM_WAIT);
    cnt_nx = state_nx == PHC_RUN ? '0 : state == PHC_RUN ? TW'(1) : cnt + TW'(cnt != TW'(MEM_TIMEOUT));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PHC_RUN;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      err <= err || timeout;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (!stall && branch_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl; output vector is
// {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err}
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [ASIZE-1:0] id_rs = '0, id_rt = '0, ex_waddr = '0;
  logic id_uses_rt = 1'b0, ex_memtoReg = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err;
  int checks = 0, errors = 0, exp_stall = 0, exp_flush = 0;
  localparam logic [6:0] RST = 7'b0011010, NORM = 7'b1100100, LU = 7'b0001100,
                         BR = 7'b1111100, FRZ = 7'b0000010, TOUT = 7'b1100110;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  pipe_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memtoReg(ex_memtoReg), .ex_waddr(ex_waddr), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_bubble(memwb_bubble),
`ifdef PIPE_PERF_CNT_EN
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .mem_err(mem_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk(tag, {25'b0, pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err}, {25'b0, exp});
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!exp[6]) exp_stall++;
      if (exp[4]) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set_lu(input logic mtr, input logic [ASIZE-1:0] wa, rs, rt, input logic urt);
    ex_memtoReg = mtr;
    ex_waddr = wa;
    id_rs = rs;
    id_rt = rt;
    id_uses_rt = urt;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) tick("reset", RST);
    rst = 1'b0;
    tick("release", NORM);
    set_lu(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    tick("lu_rs", LU);
    set_lu(1'b0, 5'd5, 5'd5, 5'd0, 1'b0);
    tick("lu_after", NORM);
    set_lu(1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
    tick("lu_rt", LU);
    set_lu(1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    tick("rt_unused", NORM);
    set_lu(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    tick("waddr0", NORM);
    set_lu(1'b1, 5'd7, 5'd7, 5'd0, 1'b0);
    branch_taken = 1'b1;
    tick("br_lu", BR);
    set_lu(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    branch_taken = 1'b0;
    dmem_req = 1'b1;
    dmem_ready = 1'b1;
    tick("zero_wait", NORM);
    dmem_ready = 1'b0;
    tick("frz0", FRZ);
    branch_taken = 1'b1;
    tick("frz1_br", FRZ);
    branch_taken = 1'b0;
    tick("frz2", FRZ);
    dmem_ready = 1'b1;
    tick("ready", NORM);
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
    tick("post_ready", NORM);
    dmem_req = 1'b1;
    for (int i = 0; i < 16; i++) tick("to_wait", FRZ);
    tick("timeout", TOUT);
    dmem_req = 1'b0;
    tick("err_sticky0", NORM | 7'b1);
    tick("err_sticky1", NORM | 7'b1);
    dmem_req = 1'b1;
    tick("mw_a", FRZ | 7'b1);
    tick("mw_b", FRZ | 7'b1);
    rst = 1'b1;
    tick("rst_mid", RST);
    rst = 1'b0;
    dmem_req = 1'b0;
    tick("after_rst", NORM);
    dmem_req = 1'b1;
    for (int i = 0; i < 16; i++) tick("to2_wait", FRZ);
    tick("timeout2", TOUT);
    dmem_req = 1'b0;
    branch_taken = 1'b1;
    tick("br_after", BR | 7'b1);
    branch_taken = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    @(negedge clk);
    chk("stall_cnt", {16'b0, stall_cnt}, exp_stall);
    chk("flush_cnt", {16'b0, flush_cnt}, exp_flush);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
